// File: rtl/scale_pkg.sv
// -----------------------------------------------------------------------------
// scale_pkg
// Shared definitions for the image-scaling fetch controller:
//   - default datapath widths (pixel, address, coordinate, fraction)
//   - FSM state encoding used by scale_fetch_ctrl (also exported on dbg_state)
//   - neighbour index constants naming the four reads issued per pixel
// -----------------------------------------------------------------------------
package scale_pkg;

    localparam int DEF_PW = 16;  // pixel width
    localparam int DEF_AW = 16;  // memory address width
    localparam int DEF_CW = 11;  // integer coordinate width
    localparam int DEF_FB = 8;   // fractional bits of step / accumulators

    // Read order within one destination pixel: (m,n), (m+1,n), (m,n+1), (m+1,n+1)
    localparam logic [1:0] K_MN   = 2'd0;
    localparam logic [1:0] K_M1N  = 2'd1;
    localparam logic [1:0] K_MN1  = 2'd2;
    localparam logic [1:0] K_M1N1 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LAST    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/scale_coord_gen.sv
// -----------------------------------------------------------------------------
// scale_coord_gen
// Destination-to-source coordinate generator for one frame.
// Holds the frame configuration, the fixed-point source accumulators
// (acc_x/acc_y) and the destination pixel counters (out_x/out_y).
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   init                capture configuration, clear accumulators/counters
//   advance             step to the next destination pixel (raster order)
//   k                   neighbour index selecting which of the 4 addresses
//   src_w/src_h         source dimensions (captured on init)
//   dst_w/dst_h         destination dimensions (captured on init)
//   step_x/step_y       source step per destination pixel, FB fraction bits
//   base_addr           source frame base address (captured on init)
//   rd_addr             address of neighbour k of the current pixel
//   frac_x/frac_y       fractional part of the current source coordinate
//   row_end             current pixel is the last of its row
//   last_pixel          current pixel is the last of the frame
// -----------------------------------------------------------------------------
module scale_coord_gen
    import scale_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW,
    parameter int FB = DEF_FB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             advance,
    input  logic [1:0]       k,
    input  logic [CW-1:0]    src_w,
    input  logic [CW-1:0]    src_h,
    input  logic [CW-1:0]    dst_w,
    input  logic [CW-1:0]    dst_h,
    input  logic [CW+FB-1:0] step_x,
    input  logic [CW+FB-1:0] step_y,
    input  logic [AW-1:0]    base_addr,
    output logic [AW-1:0]    rd_addr,
    output logic [FB-1:0]    frac_x,
    output logic [FB-1:0]    frac_y,
    output logic             row_end,
    output logic             last_pixel
);

    // One extra integer bit so step*(dst-1) cannot overflow the accumulator.
    localparam int ACCW = CW + FB + 1;
    // Integer part of the accumulator.
    localparam int CRW  = CW + 1;
    localparam int PRW  = CRW + CW;

    logic [CW-1:0]    src_w_q, src_w_d;
    logic [CW-1:0]    src_h_q, src_h_d;
    logic [CW-1:0]    dst_w_q, dst_w_d;
    logic [CW-1:0]    dst_h_q, dst_h_d;
    logic [CW+FB-1:0] step_x_q, step_x_d;
    logic [CW+FB-1:0] step_y_q, step_y_d;
    logic [AW-1:0]    base_q, base_d;
    logic [ACCW-1:0]  acc_x_q, acc_x_d;
    logic [ACCW-1:0]  acc_y_q, acc_y_d;
    logic [CW-1:0]    out_x_q, out_x_d;
    logic [CW-1:0]    out_y_q, out_y_d;

    logic [CRW-1:0]   m_raw, n_raw;
    logic [CRW-1:0]   h_max, w_max;
    logic [CRW-1:0]   m_c, n_c, m1, n1;
    logic [CRW-1:0]   row_sel, col_sel;
    logic [PRW-1:0]   row_off;

    assign row_end    = (out_x_q == (dst_w_q - CW'(1)));
    assign last_pixel = row_end && (out_y_q == (dst_h_q - CW'(1)));

    always_comb begin
        src_w_d  = src_w_q;
        src_h_d  = src_h_q;
        dst_w_d  = dst_w_q;
        dst_h_d  = dst_h_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        base_d   = base_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        if (init) begin
            src_w_d  = src_w;
            src_h_d  = src_h;
            dst_w_d  = dst_w;
            dst_h_d  = dst_h;
            step_x_d = step_x;
            step_y_d = step_y;
            base_d   = base_addr;
            acc_x_d  = '0;
            acc_y_d  = '0;
            out_x_d  = '0;
            out_y_d  = '0;
        end else if (advance) begin
            if (row_end) begin
                // New row restarts x from the left edge rather than wrapping
                // the accumulator, so rounding error never carries across rows.
                out_x_d = '0;
                acc_x_d = '0;
                out_y_d = out_y_q + CW'(1);
                acc_y_d = acc_y_q + ACCW'(step_y_q);
            end else begin
                out_x_d = out_x_q + CW'(1);
                acc_x_d = acc_x_q + ACCW'(step_x_q);
            end
        end
    end

    // Source coordinates: both the base coordinate and its +1 neighbour are
    // clamped to the last valid row/column so reads never wrap into the
    // adjacent line or past the frame.
    always_comb begin
        m_raw   = acc_y_q[ACCW-1:FB];
        n_raw   = acc_x_q[ACCW-1:FB];
        h_max   = {1'b0, src_h_q} - CRW'(1);
        w_max   = {1'b0, src_w_q} - CRW'(1);
        m_c     = (m_raw > h_max) ? h_max : m_raw;
        n_c     = (n_raw > w_max) ? w_max : n_raw;
        m1      = (m_c >= h_max) ? h_max : m_c + CRW'(1);
        n1      = (n_c >= w_max) ? w_max : n_c + CRW'(1);
        row_sel = ((k == K_M1N) || (k == K_M1N1)) ? m1 : m_c;
        col_sel = ((k == K_MN1) || (k == K_M1N1)) ? n1 : n_c;
        row_off = PRW'(row_sel) * PRW'(src_w_q);
        rd_addr = base_q + AW'(row_off) + AW'(col_sel);
    end

    assign frac_x = acc_x_q[FB-1:0];
    assign frac_y = acc_y_q[FB-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_w_q  <= '0;
            src_h_q  <= '0;
            dst_w_q  <= '0;
            dst_h_q  <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            base_q   <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            out_x_q  <= '0;
            out_y_q  <= '0;
        end else begin
            src_w_q  <= src_w_d;
            src_h_q  <= src_h_d;
            dst_w_q  <= dst_w_d;
            dst_h_q  <= dst_h_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            base_q   <= base_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
        end
    end

endmodule

// File: rtl/scale_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// scale_fetch_ctrl
// Sequences the image-scaling datapath for one frame: walks destination
// pixels in raster order, issues four source reads per pixel (2x2
// neighbourhood), captures the returned data and presents it together with
// the interpolation fractions.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   start                  frame start pulse, honoured only while idle
//   src_w/src_h            source dimensions, sampled at start
//   dst_w/dst_h            destination dimensions, sampled at start
//   step_x/step_y          source step per destination pixel (1.0 = 1<<FB)
//   base_addr              source frame base address, sampled at start
//   hold                   downstream stall request
//   mem_rd_en/mem_rd_addr  read strobe and address
//   mem_rd_data            read data
//   imgmn..imgm1n1         pixels (m,n), (m+1,n), (m,n+1), (m+1,n+1)
//   frac_x/frac_y          fractional source coordinate of presented pixel
//   img_rdy                one-cycle pulse: pixel and frac outputs valid
//   busy                   frame in progress
//   done                   one-cycle pulse after the last pixel
//   dbg_state              current FSM state (scale_pkg::state_t encoding)
//
// Interface timing: a read is issued in every cycle mem_rd_en=1 and its data
// must be on mem_rd_data exactly one cycle later (no back-pressure on the
// memory side). img_rdy is a pulse with no ready handshake; the consumer
// stalls the next pixel with hold, sampled only as a pixel is presented and
// while already held, so a fetch in progress always completes.
// -----------------------------------------------------------------------------
module scale_fetch_ctrl
    import scale_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW,
    parameter int FB = DEF_FB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    src_w,
    input  logic [CW-1:0]    src_h,
    input  logic [CW-1:0]    dst_w,
    input  logic [CW-1:0]    dst_h,
    input  logic [CW+FB-1:0] step_x,
    input  logic [CW+FB-1:0] step_y,
    input  logic [AW-1:0]    base_addr,
    input  logic             hold,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [PW-1:0]    mem_rd_data,
    output logic [PW-1:0]    imgmn,
    output logic [PW-1:0]    imgm1n,
    output logic [PW-1:0]    imgmn1,
    output logic [PW-1:0]    imgm1n1,
    output logic [FB-1:0]    frac_x,
    output logic [FB-1:0]    frac_y,
    output logic             img_rdy,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [FB-1:0]       frac_x_q, frac_x_d;
    logic [FB-1:0]       frac_y_q, frac_y_d;
    logic                rd_vld_q, rd_vld_d;
    logic [1:0]          rd_k_q, rd_k_d;
    logic [3:0][PW-1:0]  pix_q, pix_d;

    logic                cg_init;
    logic                cg_advance;
    logic                rd_en;
    logic [AW-1:0]       cg_addr;
    logic [FB-1:0]       cg_frac_x;
    logic [FB-1:0]       cg_frac_y;
    logic                row_end;
    logic                last_pixel;

    scale_coord_gen #(
        .AW (AW),
        .CW (CW),
        .FB (FB)
    ) u_coord (
        .clk        (clk),
        .reset      (reset),
        .init       (cg_init),
        .advance    (cg_advance),
        .k          (k_q),
        .src_w      (src_w),
        .src_h      (src_h),
        .dst_w      (dst_w),
        .dst_h      (dst_h),
        .step_x     (step_x),
        .step_y     (step_y),
        .base_addr  (base_addr),
        .rd_addr    (cg_addr),
        .frac_x     (cg_frac_x),
        .frac_y     (cg_frac_y),
        .row_end    (row_end),
        .last_pixel (last_pixel)
    );

    // FSM next-state and strobes.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        frac_x_d   = frac_x_q;
        frac_y_d   = frac_y_q;
        cg_init    = 1'b0;
        cg_advance = 1'b0;
        rd_en      = 1'b0;
        img_rdy    = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cg_init = 1'b1;
                    k_d     = K_MN;
                    // An empty destination finishes without touching memory.
                    if ((dst_w == '0) || (dst_h == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                rd_en = 1'b1;
                k_d   = k_q + 2'd1;
                if (k_q == K_M1N1) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                // Accumulators still describe this pixel here; they move on
                // during PRESENT, so the fractions are latched now and held
                // for the consumer alongside the pixel registers.
                frac_x_d = cg_frac_x;
                frac_y_d = cg_frac_y;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                img_rdy    = 1'b1;
                cg_advance = 1'b1;
                k_d        = K_MN;
                if (last_pixel) begin
                    state_d = ST_DONE;
                end else if (hold) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!hold) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after its strobe; remember which neighbour
    // each outstanding read belongs to and drop the data into that register.
    always_comb begin
        rd_vld_d = rd_en;
        rd_k_d   = k_q;
        pix_d    = pix_q;
        if (rd_vld_q) begin
            pix_d[rd_k_q] = mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            frac_x_q <= '0;
            frac_y_q <= '0;
            rd_vld_q <= 1'b0;
            rd_k_q   <= '0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            frac_x_q <= frac_x_d;
            frac_y_q <= frac_y_d;
            rd_vld_q <= rd_vld_d;
            rd_k_q   <= rd_k_d;
            pix_q    <= pix_d;
        end
    end

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_en ? cg_addr : '0;
    assign imgmn       = pix_q[K_MN];
    assign imgm1n      = pix_q[K_M1N];
    assign imgmn1      = pix_q[K_MN1];
    assign imgm1n1     = pix_q[K_M1N1];
    assign frac_x      = frac_x_q;
    assign frac_y      = frac_y_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_scale_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scale_fetch_ctrl
// Self-checking bench for scale_fetch_ctrl. A behavioural model computes every
// presented pixel from the frame geometry (source coordinate = destination
// index * step, clamped), the memory returns a known function of the address,
// and a scoreboard queue holds the expected pixel/fraction tuples in order.
// -----------------------------------------------------------------------------
module tb_scale_fetch_ctrl;

    localparam int PW = 16;
    localparam int AW = 16;
    localparam int CW = 11;
    localparam int FB = 8;
    localparam int TW = 4 * PW + 2 * FB;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             start = 1'b0;
    logic             hold  = 1'b0;
    logic [CW-1:0]    src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
    logic [CW+FB-1:0] step_x = '0, step_y = '0;
    logic [AW-1:0]    base_addr = '0;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_rd_addr;
    logic [PW-1:0]    mem_rd_data;
    logic [PW-1:0]    imgmn, imgm1n, imgmn1, imgm1n1;
    logic [FB-1:0]    frac_x, frac_y;
    logic             img_rdy, busy, done;
    logic [2:0]       dbg_state;

    scale_fetch_ctrl #(.PW(PW), .AW(AW), .CW(CW), .FB(FB)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_w       (src_w),
        .src_h       (src_h),
        .dst_w       (dst_w),
        .dst_h       (dst_h),
        .step_x      (step_x),
        .step_y      (step_y),
        .base_addr   (base_addr),
        .hold        (hold),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .imgmn       (imgmn),
        .imgm1n      (imgm1n),
        .imgmn1      (imgmn1),
        .imgm1n1     (imgm1n1),
        .frac_x      (frac_x),
        .frac_y      (frac_y),
        .img_rdy     (img_rdy),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Source memory: one-cycle read latency, garbage when not reading.
    logic [PW-1:0] mem_xor = '0;
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? (mem_rd_addr ^ mem_xor) : PW'($urandom);
    end

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] obs_log[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] mem_val(input int r, input int c, input int sw, input int base);
        logic [AW-1:0] a;
        a = AW'(base + r * sw + c);
        return a ^ mem_xor;
    endfunction

    function automatic logic [TW-1:0] model_pixel(input int ox, input int oy, input int sw, input int sh,
                                                   input int stx, input int sty, input int base);
        int ax, ay, m, n, m1, n1;
        ax = ox * stx;
        ay = oy * sty;
        m  = ay / (1 << FB);
        n  = ax / (1 << FB);
        if (m > sh - 1) m = sh - 1;
        if (n > sw - 1) n = sw - 1;
        m1 = (m + 1 > sh - 1) ? sh - 1 : m + 1;
        n1 = (n + 1 > sw - 1) ? sw - 1 : n + 1;
        return {mem_val(m, n, sw, base), mem_val(m1, n, sw, base),
                mem_val(m, n1, sw, base), mem_val(m1, n1, sw, base),
                FB'(ax % (1 << FB)), FB'(ay % (1 << FB))};
    endfunction

    // ---------------- driver: one whole frame ----------------
    // hold_len>0 raises hold from pixel 0's PRESENT for hold_len cycles.
    // restart_at>0 pulses start (with dst_w=1) at that frame cycle.
    task automatic run_frame(input string name, input int sw, input int sh, input int dw, input int dh,
                             input int stx, input int sty, input int base,
                             input int hold_len, input int restart_at);
        int npix, cyc, got, reads, exp_cyc, done_cyc;
        bit done_seen;
        logic [TW-1:0] exp_t;
        exp_q.delete();
        obs_log.delete();
        for (int oy = 0; oy < dh; oy++)
            for (int ox = 0; ox < dw; ox++)
                exp_q.push_back(model_pixel(ox, oy, sw, sh, stx, sty, base));
        npix     = dw * dh;
        done_cyc = (npix == 0) ? 1 : 6 * npix + ((hold_len > 0 && npix > 1) ? hold_len : 0) + 1;
        got = 0; reads = 0; done_seen = 1'b0;

        @(posedge clk); #1;
        src_w = CW'(sw); src_h = CW'(sh); dst_w = CW'(dw); dst_h = CW'(dh);
        step_x = (CW+FB)'(stx); step_y = (CW+FB)'(sty); base_addr = AW'(base);
        start = 1'b1; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done_seen && cyc <= done_cyc + 20) begin
            @(negedge clk);
            if (cyc == 1) check($sformatf("%s busy_at_c1", name), busy, 1'b1);
            if (mem_rd_en) reads++;
            if (img_rdy) begin
                exp_cyc = 6 + 6 * got + ((hold_len > 0 && got >= 1) ? hold_len : 0);
                check($sformatf("%s rdy_cycle px%0d", name, got), cyc, exp_cyc);
                if (exp_q.size() == 0) begin
                    check($sformatf("%s extra_img_rdy", name), 1'b1, 1'b0);
                end else begin
                    exp_t = exp_q.pop_front();
                    check($sformatf("%s pixel px%0d", name, got),
                          {imgmn, imgm1n, imgmn1, imgm1n1, frac_x, frac_y}, exp_t);
                end
                obs_log.push_back({imgmn, imgm1n, imgmn1, imgm1n1, frac_x, frac_y});
                got++;
            end
            if (hold_len > 0 && cyc > 6 && cyc <= 6 + hold_len)
                check($sformatf("%s held_quiet c%0d", name, cyc), {mem_rd_en, img_rdy}, 2'b00);
            if (hold_len > 0 && npix > 1 && cyc == 7 + hold_len)
                check($sformatf("%s fetch_after_hold", name), mem_rd_en, 1'b1);
            if (done) begin
                check($sformatf("%s done_cycle", name), cyc, done_cyc);
                done_seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                hold  = (hold_len > 0 && cyc >= 6 && cyc < 6 + hold_len);
                start = (cyc == restart_at);
                dst_w = (cyc == restart_at) ? CW'(1) : CW'(dw);
            end
        end
        check($sformatf("%s done_seen", name), done_seen, 1'b1);
        check($sformatf("%s pixel_count", name), got, npix);
        check($sformatf("%s read_count", name), reads, 4 * npix);
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0; dst_w = CW'(dw);
        @(negedge clk);
        check($sformatf("%s idle_after_done", name), {busy, mem_rd_en, done}, 3'b000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_rd_en, mem_rd_addr, imgmn, imgm1n, imgmn1, imgm1n1,
                                frac_x, frac_y, img_rdy, busy, done}, '0);
        #1 reset = 1'b1;

        // Identity 4x4; start pulse during DONE must be ignored.
        mem_xor = '0;
        run_frame("ident", 4, 4, 4, 4, 256, 256, 0, 0, 97);
        if (obs_log.size() == 16) begin
            check("ident px(0,0)", obs_log[0][TW-1:2*FB],  {16'd0, 16'd4, 16'd1, 16'd5});
            check("ident px(0,3)", obs_log[3][TW-1:2*FB],  {16'd3, 16'd7, 16'd3, 16'd7});
            check("ident px(3,3)", obs_log[15][TW-1:2*FB], {16'd15, 16'd15, 16'd15, 16'd15});
        end else begin
            check("ident log_size", obs_log.size(), 16);
        end

        // Upscale 2x2 -> 4x4.
        run_frame("upscale", 2, 2, 4, 4, 128, 128, 0, 0, 0);
        if (obs_log.size() == 16) begin
            check("up px(0,1)", obs_log[1],  {16'd0, 16'd2, 16'd1, 16'd3, 8'h80, 8'h00});
            check("up px(3,3)", obs_log[15], {16'd3, 16'd3, 16'd3, 16'd3, 8'h80, 8'h80});
        end else begin
            check("up log_size", obs_log.size(), 16);
        end

        // Hold from pixel 0's PRESENT for 10 cycles.
        mem_xor = 16'h1234;
        run_frame("hold", 4, 4, 2, 2, 256, 256, 16'h0100, 10, 0);

        // Start while busy (with a different dst_w) must not disturb the frame.
        run_frame("busy_start", 4, 4, 3, 3, 256, 256, 16'h0020, 0, 10);

        // Degenerate destinations.
        run_frame("dst_w0", 4, 4, 0, 3, 256, 256, 0, 0, 0);
        run_frame("dst_h0", 4, 4, 3, 0, 256, 256, 0, 0, 0);

        // Reset while fetching neighbour k=2 of pixel 0.
        mem_xor = '0;
        @(posedge clk); #1;
        src_w = 4; src_h = 4; dst_w = 4; dst_h = 4;
        step_x = 256; step_y = 256; base_addr = 16'h0100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst k2_read", {mem_rd_en, mem_rd_addr}, {1'b1, 16'h0101});
        #1 reset = 1'b0;
        #1;
        check("rst async_clear", {mem_rd_en, mem_rd_addr, imgmn, imgm1n, imgmn1, imgm1n1,
                                  frac_x, frac_y, img_rdy, busy, done}, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst quiet c%0d", i), {done, busy, mem_rd_en}, 3'b000);
        end
        #1 reset = 1'b1;
        run_frame("after_reset", 4, 4, 4, 4, 256, 256, 16'h0100, 0, 0);

        // Randomized geometry, steps, base (incl. address wrap) and data pattern.
        for (int t = 0; t < 5; t++) begin
            int sw, sh, dw, dh, stx, sty, base;
            sw      = $urandom_range(1, 8);
            sh      = $urandom_range(1, 8);
            dw      = $urandom_range(1, 5);
            dh      = $urandom_range(1, 5);
            stx     = $urandom_range(0, 1024);
            sty     = $urandom_range(0, 1024);
            base    = $urandom_range(0, 65535);
            mem_xor = PW'($urandom);
            run_frame($sformatf("rand%0d", t), sw, sh, dw, dh, stx, sty, base, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
